// File: rtl/peripheral_mpram_axi4_initiator.sv
// SRAM-style request port to single-beat AXI4 master bridge.
// One transaction in flight; completion reported by a one-cycle rvalid_o.
module peripheral_mpram_axi4_initiator #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_STRB_WIDTH = 8,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_TXN_ID = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [7:0]                axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  output logic                      axi_aw_lock,
  output logic [3:0]                axi_aw_cache,
  output logic [2:0]                axi_aw_prot,
  output logic [3:0]                axi_aw_qos,
  output logic [3:0]                axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] axi_w_user,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [7:0]                axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic                      axi_ar_lock,
  output logic [3:0]                axi_ar_cache,
  output logic [2:0]                axi_ar_prot,
  output logic [3:0]                axi_ar_qos,
  output logic [3:0]                axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_e;

  state_e state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_STRB_WIDTH-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic                      rvalid_q;
  logic                      err_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    gnt_o        = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o     = req_i;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_i) begin
          state_d = we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        axi_aw_valid = ~aw_done_q;
        axi_w_valid  = ~w_done_q;
        if (axi_aw_valid && axi_aw_ready) begin
          aw_done_d = 1'b1;
        end
        if (axi_w_valid && axi_w_ready) begin
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Never grant while reset is held, even before the state register settles
    if (rst_i) begin
      gnt_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      be_q     <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (state_q == IDLE && req_i) begin
        addr_q <= addr_i;
        be_q   <= be_i;
        data_q <= data_i;
      end
      if (state_q == WR_RESP && axi_b_valid) begin
        rvalid_q <= 1'b1;
        err_q    <= axi_b_resp[1];
      end
      if (state_q == RD_RESP && axi_r_valid) begin
        rvalid_q <= 1'b1;
        err_q    <= axi_r_resp[1];
        rdata_q  <= axi_r_data;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  assign axi_aw_id     = AXI_TXN_ID;
  assign axi_aw_addr   = addr_q;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = AX_SIZE;
  assign axi_aw_burst  = 2'b01;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'd0;
  assign axi_aw_prot   = 3'd0;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = '0;

  assign axi_w_data = data_q;
  assign axi_w_strb = be_q;
  assign axi_w_last = 1'b1;
  assign axi_w_user = '0;

  assign axi_ar_id     = AXI_TXN_ID;
  assign axi_ar_addr   = addr_q;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = AX_SIZE;
  assign axi_ar_burst  = 2'b01;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'd0;
  assign axi_ar_prot   = 3'd0;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;

  // IDs, last and user sidebands carry nothing we act on
  logic unused_inputs;
  assign unused_inputs = ^{axi_b_id, axi_b_resp[0], axi_b_user,
                           axi_r_id, axi_r_resp[0], axi_r_last,
                           axi_r_user};

endmodule

// File: tb/tb_peripheral_mpram_axi4_initiator.sv
// Bench for the AXI4 initiator: scripted slave, scoreboard of completions
// and cycle-accurate checks of handshake timing.
module tb_peripheral_mpram_axi4_initiator;

  localparam int IW = 10;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int UW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [SW-1:0] be_i;
  logic [DW-1:0] data_i;
  logic          gnt_o, rvalid_o, err_o;
  logic [DW-1:0] rdata_o;

  logic [IW-1:0] aw_id, ar_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [2:0]    aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]    aw_burst, ar_burst;
  logic          aw_lock, ar_lock;
  logic [3:0]    aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [UW-1:0] aw_user, ar_user, w_user;
  logic          aw_valid, w_valid, ar_valid, b_ready, r_ready, w_last;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;

  logic          aw_ready = 1'b0;
  logic          w_ready  = 1'b0;
  logic          ar_ready = 1'b0;
  logic          b_valid  = 1'b0;
  logic          r_valid  = 1'b0;
  logic [1:0]    b_resp   = 2'b00;
  logic [1:0]    r_resp   = 2'b00;
  logic [DW-1:0] r_data   = '0;

  peripheral_mpram_axi4_initiator dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .data_i(data_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len),
    .axi_aw_size(aw_size), .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock),
    .axi_aw_cache(aw_cache), .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos),
    .axi_aw_region(aw_region), .axi_aw_user(aw_user),
    .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last),
    .axi_w_user(w_user), .axi_w_valid(w_valid), .axi_w_ready(w_ready),
    .axi_b_id('0), .axi_b_resp(b_resp), .axi_b_user('0),
    .axi_b_valid(b_valid), .axi_b_ready(b_ready),
    .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len),
    .axi_ar_size(ar_size), .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock),
    .axi_ar_cache(ar_cache), .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos),
    .axi_ar_region(ar_region), .axi_ar_user(ar_user),
    .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
    .axi_r_id('0), .axi_r_data(r_data), .axi_r_resp(r_resp),
    .axi_r_last(1'b1), .axi_r_user('0),
    .axi_r_valid(r_valid), .axi_r_ready(r_ready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // slave behaviour knobs: cycles of stall before ready/valid
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_wt = 0, w_wt = 0, ar_wt = 0, b_wt = 0, r_wt = 0;
  logic [1:0]    cfg_bresp = 2'b00;
  logic [1:0]    cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;

  always @(negedge clk) begin
    if (aw_valid === 1'b1) begin
      aw_ready = (aw_wt == aw_dly);
      if (!aw_ready) aw_wt++;
    end else begin
      aw_ready = 1'b0; aw_wt = 0;
    end
    if (w_valid === 1'b1) begin
      w_ready = (w_wt == w_dly);
      if (!w_ready) w_wt++;
    end else begin
      w_ready = 1'b0; w_wt = 0;
    end
    if (ar_valid === 1'b1) begin
      ar_ready = (ar_wt == ar_dly);
      if (!ar_ready) ar_wt++;
    end else begin
      ar_ready = 1'b0; ar_wt = 0;
    end
    if (b_ready === 1'b1) begin
      b_valid = (b_wt == b_dly);
      b_resp  = cfg_bresp;
      if (!b_valid) b_wt++;
    end else begin
      b_valid = 1'b0; b_wt = 0;
    end
    if (r_ready === 1'b1) begin
      r_valid = (r_wt == r_dly);
      r_resp  = cfg_rresp;
      r_data  = cfg_rdata;
      if (!r_valid) r_wt++;
    end else begin
      r_valid = 1'b0; r_wt = 0;
    end
  end

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] last_rd = '0;
  int            n_rv = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rvalid_o === 1'b1) begin
      n_rv++;
      if (sb.size() == 0) begin
        check("spurious_rvalid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_err", err_o, e.err);
        check("sb_rdata", rdata_o, e.rdata);
      end
    end
  end

  task automatic push_exp(input logic we);
    exp_t e;
    if (!we) last_rd = cfg_rdata;
    e.err   = we ? cfg_bresp[1] : cfg_rresp[1];
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic start(input logic we, input logic [AW-1:0] a,
                       input logic [SW-1:0] be, input logic [DW-1:0] d);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; data_i = d;
    #1;
    check("gnt", gnt_o, 1);
    push_exp(we);
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] a,
                         input logic [SW-1:0] be, input logic [DW-1:0] d);
    int k;
    start(we, a, be, d);
    @(negedge clk);
    req_i = 1'b0;
    k = 1;
    while (rvalid_o !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("txn_done", rvalid_o, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awv"}, aw_valid, 0);
    check({tag, "_wv"}, w_valid, 0);
    check({tag, "_arv"}, ar_valid, 0);
    check({tag, "_brdy"}, b_ready, 0);
    check({tag, "_rrdy"}, r_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0;
    addr_i = '0; be_i = '0; data_i = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check_quiet("rst");
    req_i = 1'b0; rst_i = 1'b0;
    @(negedge clk);

    // zero-wait write
    start(1'b1, 64'h100, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    check("w1_awv", aw_valid, 1);
    check("w1_wv", w_valid, 1);
    check("w1_awaddr", aw_addr, 64'h100);
    check("w1_wdata", w_data, 64'hDEADBEEF_CAFEF00D);
    check("w1_wstrb", w_strb, 8'hFF);
    check("w1_awlen", aw_len, 0);
    check("w1_awsize", aw_size, 3);
    check("w1_awburst", aw_burst, 1);
    check("w1_wlast", w_last, 1);
    check("w1_awid", aw_id, 0);
    check("w1_gnt_busy", gnt_o, 0);
    req_i = 1'b0;
    @(negedge clk);
    check("w1_brdy", b_ready, 1);
    check("w1_awv_drop", aw_valid, 0);
    check("w1_wv_drop", w_valid, 0);
    @(negedge clk);
    check("w1_rvalid", rvalid_o, 1);
    check("w1_err", err_o, 0);
    @(negedge clk);

    // decoupled AW/W: W accepted at once, AW stalls until cycle 4
    aw_dly = 3;
    start(1'b1, 64'h200, 8'h0F, 64'h1111_2222_3333_4444);
    @(negedge clk);
    req_i = 1'b0;
    check("dc1_awv", aw_valid, 1);
    check("dc1_wv", w_valid, 1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("dc_awv_hold", aw_valid, 1);
      check("dc_wv_low", w_valid, 0);
      check("dc_brdy_low", b_ready, 0);
      check("dc_awaddr", aw_addr, 64'h200);
    end
    @(negedge clk);
    check("dc5_brdy", b_ready, 1);
    check("dc5_awv", aw_valid, 0);
    @(negedge clk);
    check("dc6_rvalid", rvalid_o, 1);
    aw_dly = 0;
    @(negedge clk);

    // read with stalled response
    r_dly = 3; cfg_rdata = 64'h1234; cfg_rresp = 2'b00;
    start(1'b0, 64'h2008, 8'h00, 64'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("rd_gnt_busy", gnt_o, 0);
      check("rd_rvalid_early", rvalid_o, 0);
      if (c == 1) begin
        check("rd1_arv", ar_valid, 1);
        check("rd1_araddr", ar_addr, 64'h2008);
        check("rd1_arsize", ar_size, 3);
        check("rd1_arlen", ar_len, 0);
      end
      if (c == 2) check("rd2_rrdy", r_ready, 1);
      if (c == 5) req_i = 1'b0;
    end
    @(negedge clk);
    check("rd6_rvalid", rvalid_o, 1);
    check("rd6_rdata", rdata_o, 64'h1234);
    r_dly = 0;
    @(negedge clk);

    // error responses
    cfg_rresp = 2'b10; cfg_rdata = 64'hA5A5;
    run_txn(1'b0, 64'h3000, 8'h00, 64'h0);
    check("rd_slverr", err_o, 1);
    cfg_bresp = 2'b11;
    run_txn(1'b1, 64'h3008, 8'h3C, 64'h99);
    check("wr_decerr", err_o, 1);
    check("wr_keeps_rdata", rdata_o, 64'hA5A5);
    cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    @(negedge clk);

    // back-to-back write then read with req held high
    cfg_rdata = 64'h0BAD_F00D;
    n0 = n_rv;
    start(1'b1, 64'h400, 8'hFF, 64'h55);
    @(negedge clk);
    we_i = 1'b0; addr_i = 64'h408;
    @(negedge clk);
    @(negedge clk);
    check("b2b_rvalid1", rvalid_o, 1);
    check("b2b_gnt2", gnt_o, 1);
    push_exp(1'b0);
    @(negedge clk);
    req_i = 1'b0;
    check("b2b_arv", ar_valid, 1);
    check("b2b_araddr", ar_addr, 64'h408);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rvalid2", rvalid_o, 1);
    check("b2b_rdata", rdata_o, 64'h0BAD_F00D);
    repeat (3) @(negedge clk);
    check("b2b_pulses", n_rv - n0, 2);

    // reset during WR_REQ with AW stalled
    aw_dly = 10;
    start(1'b1, 64'h500, 8'hFF, 64'h77);
    @(negedge clk);
    check("mr_awv", aw_valid, 1);
    rst_i = 1'b1; req_i = 1'b0;
    @(negedge clk);
    check_quiet("mr");
    check("mr_rvalid", rvalid_o, 0);
    check("mr_rdata", rdata_o, 0);
    rst_i = 1'b0; sb.delete(); last_rd = '0; aw_dly = 0;
    n0 = n_rv;
    repeat (5) @(negedge clk);
    check("mr_no_pulse", n_rv - n0, 0);
    cfg_rdata = 64'hCAFE;
    run_txn(1'b0, 64'h600, 8'h00, 64'h0);
    check("mr_rd_rdata", rdata_o, 64'hCAFE);
    check("mr_rd_err", err_o, 0);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
